// File: rtl/sram_like_arbiter.sv
// Two-requester arbiter onto one SRAM-like bus port.
// A 1-bit routing FIFO steers in-order responses back to their source.
module sram_like_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic        proto_err
);

  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_INST = 2'd1,
    G_DATA = 2'd2
  } grant_t;

  grant_t state, state_nxt;

  logic                 rr_last;
  logic [MAX_OUTST-1:0] fifo;
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        cnt;

  logic full, empty, sel_data, grant_data;
  logic act_req, show, hs, pop, head;

  // sel_data: contest winner when unlocked (1 = data port)
  always_comb begin
    full    = (cnt == CW'(MAX_OUTST));
    empty   = (cnt == '0);
    sel_data = data_req;
    if (inst_req & data_req)
      sel_data = DATA_PRIO ? 1'b1 : ~rr_last;
    unique case (state)
      G_INST:  grant_data = 1'b0;
      G_DATA:  grant_data = 1'b1;
      default: grant_data = sel_data;
    endcase
    act_req = grant_data ? data_req : inst_req;
    show    = inst_req | data_req | (state != G_NONE);
    bus_req = act_req & ~full;
    hs      = bus_req & bus_addr_ok;
    pop     = bus_data_ok & ~empty;
    head    = fifo[rptr];
  end

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (show) begin
      bus_wr    = grant_data ? data_wr    : inst_wr;
      bus_size  = grant_data ? data_size  : inst_size;
      bus_wstrb = grant_data ? data_wstrb : inst_wstrb;
      bus_addr  = grant_data ? data_addr  : inst_addr;
      bus_wdata = grant_data ? data_wdata : inst_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      G_NONE: begin
        if (bus_req & ~bus_addr_ok)
          state_nxt = grant_data ? G_DATA : G_INST;
      end
      G_INST, G_DATA: begin
        if (~act_req | bus_addr_ok)
          state_nxt = G_NONE;
      end
      default: state_nxt = G_NONE;
    endcase
  end

  assign inst_addr_ok = hs & ~grant_data;
  assign data_addr_ok = hs & grant_data;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;
  assign outst_cnt    = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= G_NONE;
      rr_last   <= 1'b0;
      fifo      <= '0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        fifo[wptr] <= grant_data;
        wptr       <= wptr + AW'(1);
        if (!DATA_PRIO)
          rr_last <= grant_data;
      end
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({hs, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus_data_ok & empty)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: vector table, directed corner
// sequences, and random traffic against a queue-based model.
module tb_sram_like_arbiter;

  localparam int MAXO = 4;
  localparam logic [31:0] IA = 32'h1C00_0000;
  localparam logic [31:0] DA = 32'h8000_0010;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic [2:0]  outst_cnt;
  logic        proto_err;

  logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        r_bus_req, r_bus_wr;
  logic [1:0]  r_bus_size;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [2:0]  r_outst_cnt;
  logic        r_proto_err;

  sram_like_arbiter #(.MAX_OUTST(MAXO), .DATA_PRIO(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .outst_cnt(outst_cnt), .proto_err(proto_err)
  );

  sram_like_arbiter #(.MAX_OUTST(MAXO), .DATA_PRIO(1'b0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(r_inst_addr_ok), .inst_data_ok(r_inst_data_ok),
    .inst_rdata(r_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(r_data_addr_ok), .data_data_ok(r_data_data_ok),
    .data_rdata(r_data_rdata),
    .bus_req(r_bus_req), .bus_wr(r_bus_wr), .bus_size(r_bus_size),
    .bus_wstrb(r_bus_wstrb), .bus_addr(r_bus_addr), .bus_wdata(r_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .outst_cnt(r_outst_cnt), .proto_err(r_proto_err)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [143:0] got,
                     input logic [143:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic do_reset();
    idle_in();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  in;
    logic [31:0] rd;
    logic [4:0]  ex;
    logic [31:0] baddr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[23];

  // model state for random traffic (data-priority instance)
  int  m_lock;
  bit  m_q[$];
  bit  m_err;

  logic [143:0] got_v, exp_v;

  initial begin
    resetn     = 1'b0;
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'hF;
    inst_addr  = IA;
    inst_wdata = 32'h0;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_wstrb = 4'h3;
    data_addr  = DA;
    data_wdata = 32'hCAFE_0001;
    idle_in();

    // in: ireq dreq bao bdo / ex: iaok daok idok ddok breq
    tbl[0]  = '{4'b0000, 32'h0,         5'b00000, 32'h0, 3'd0};
    tbl[1]  = '{4'b1010, 32'h0,         5'b10001, IA,    3'd0};
    tbl[2]  = '{4'b0000, 32'h0,         5'b00000, 32'h0, 3'd1};
    tbl[3]  = '{4'b0000, 32'h0,         5'b00000, 32'h0, 3'd1};
    tbl[4]  = '{4'b0001, 32'hDEADBEEF,  5'b00100, 32'h0, 3'd1};
    tbl[5]  = '{4'b1110, 32'h0,         5'b01001, DA,    3'd0};
    tbl[6]  = '{4'b1110, 32'h0,         5'b01001, DA,    3'd1};
    tbl[7]  = '{4'b1010, 32'h0,         5'b10001, IA,    3'd2};
    tbl[8]  = '{4'b0001, 32'h1111_1111, 5'b00010, 32'h0, 3'd3};
    tbl[9]  = '{4'b0001, 32'h2222_2222, 5'b00010, 32'h0, 3'd2};
    tbl[10] = '{4'b0001, 32'h3333_3333, 5'b00100, 32'h0, 3'd1};
    tbl[11] = '{4'b0000, 32'h0,         5'b00000, 32'h0, 3'd0};
    tbl[12] = '{4'b1000, 32'h0,         5'b00001, IA,    3'd0};
    tbl[13] = '{4'b1100, 32'h0,         5'b00001, IA,    3'd0};
    tbl[14] = '{4'b1110, 32'h0,         5'b10001, IA,    3'd0};
    tbl[15] = '{4'b0110, 32'h0,         5'b01001, DA,    3'd1};
    tbl[16] = '{4'b0001, 32'h4444_4444, 5'b00100, 32'h0, 3'd2};
    tbl[17] = '{4'b0001, 32'h5555_5555, 5'b00010, 32'h0, 3'd1};
    tbl[18] = '{4'b0100, 32'h0,         5'b00001, DA,    3'd0};
    tbl[19] = '{4'b1000, 32'h0,         5'b00000, DA,    3'd0};
    tbl[20] = '{4'b1010, 32'h0,         5'b10001, IA,    3'd0};
    tbl[21] = '{4'b0001, 32'h6666_6666, 5'b00100, 32'h0, 3'd1};
    tbl[22] = '{4'b0000, 32'h0,         5'b00000, 32'h0, 3'd0};

    do_reset();
    @(negedge clk);
    chk("reset", 144'({inst_addr_ok, data_addr_ok, inst_data_ok,
        data_data_ok, bus_req, bus_addr, outst_cnt, proto_err}), 144'(0));
    tick();

    for (int i = 0; i < 23; i++) begin
      {inst_req, data_req, bus_addr_ok, bus_data_ok} = tbl[i].in;
      bus_rdata = tbl[i].rd;
      @(negedge clk);
      got_v = 144'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                    bus_req, bus_addr, outst_cnt, inst_rdata, data_rdata});
      exp_v = 144'({tbl[i].ex, tbl[i].baddr, tbl[i].cnt,
                    tbl[i].ex[2] ? tbl[i].rd : 32'h0,
                    tbl[i].ex[1] ? tbl[i].rd : 32'h0});
      chk($sformatf("tbl%0d", i), got_v, exp_v);
      tick();
    end

    // fifo full: four accepts, then pop and request in the same cycle
    idle_in();
    for (int i = 0; i < 4; i++) begin
      data_req = 1'b1;
      bus_addr_ok = 1'b1;
      @(negedge clk);
      chk("t5_fill", 144'(data_addr_ok), 144'(1));
      tick();
    end
    bus_data_ok = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("t5_cnt4", 144'(outst_cnt), 144'(4));
    chk("t5_block", 144'({bus_req, data_addr_ok}), 144'(0));
    chk("t5_pop", 144'({data_data_ok, data_rdata}), 144'({1'b1, 32'h7777_7777}));
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("t5_next", 144'({outst_cnt, bus_req, data_addr_ok}), 144'({3'd3, 2'b11}));
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      bus_data_ok = 1'b1;
      @(negedge clk);
      chk("t5_drain", 144'({data_data_ok, inst_data_ok}), 144'(2'b10));
      tick();
    end
    idle_in();

    // stray response sets the sticky error; async reset clears state
    bus_data_ok = 1'b1;
    @(negedge clk);
    chk("t6_nodok", 144'({inst_data_ok, data_data_ok, outst_cnt, proto_err}), 144'(0));
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_err", 144'(proto_err), 144'(1));
    repeat (3) tick();
    @(negedge clk);
    chk("t6_sticky", 144'(proto_err), 144'(1));
    tick();
    inst_req = 1'b1;
    bus_addr_ok = 1'b1;
    repeat (2) tick();
    idle_in();
    chk("t6_pre", 144'(outst_cnt), 144'(2));
    #2 resetn = 1'b0;
    #1;
    chk("t6_async", 144'({outst_cnt, proto_err, bus_req}), 144'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // round-robin instance: alternating grants and routing
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inst_req = 1'b1;
      data_req = 1'b1;
      bus_addr_ok = 1'b1;
      @(negedge clk);
      chk("t4_acc", 144'({r_inst_addr_ok, r_data_addr_ok}),
          144'((i % 2 == 0) ? 2'b01 : 2'b10));
      tick();
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin
      bus_data_ok = 1'b1;
      bus_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      chk("t4_rsp", 144'({r_inst_data_ok, r_data_data_ok, r_inst_rdata, r_data_rdata}),
          (i % 2 == 0) ? 144'({2'b01, 32'h0, bus_rdata}) : 144'({2'b10, bus_rdata, 32'h0}));
      tick();
    end
    idle_in();

    // random traffic against the queue model
    do_reset();
    m_lock = -1;
    m_q.delete();
    m_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit src, req, show, full, breq, hs, pop, head;
      if (c % 500 == 499) begin
        idle_in();
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
        m_lock = -1;
        m_q.delete();
        m_err = 1'b0;
      end
      inst_req    = 1'($urandom);
      data_req    = 1'($urandom);
      inst_wr     = 1'($urandom);
      data_wr     = 1'($urandom);
      inst_size   = 2'($urandom_range(0, 2));
      data_size   = 2'($urandom_range(0, 2));
      inst_wstrb  = 4'($urandom);
      data_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = 1'($urandom);
      bus_data_ok = ($urandom_range(0, 9) < 4);
      bus_rdata   = $urandom;

      if (m_lock >= 0) src = (m_lock == 1);
      else src = data_req;
      req  = src ? data_req : inst_req;
      show = inst_req | data_req | (m_lock >= 0);
      full = (m_q.size() == MAXO);
      breq = req & ~full;
      hs   = breq & bus_addr_ok;
      pop  = bus_data_ok & (m_q.size() > 0);
      head = pop ? m_q[0] : 1'b0;

      exp_v = {hs & ~src, pop & ~head, (pop & ~head) ? bus_rdata : 32'h0,
               hs & src, pop & head, (pop & head) ? bus_rdata : 32'h0,
               breq,
               show ? (src ? data_wr : inst_wr) : 1'b0,
               show ? (src ? data_size : inst_size) : 2'b0,
               show ? (src ? data_wstrb : inst_wstrb) : 4'b0,
               show ? (src ? data_addr : inst_addr) : 32'h0,
               show ? (src ? data_wdata : inst_wdata) : 32'h0,
               3'(m_q.size()), m_err};
      @(negedge clk);
      got_v = {inst_addr_ok, inst_data_ok, inst_rdata,
               data_addr_ok, data_data_ok, data_rdata,
               bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
               outst_cnt, proto_err};
      chk("rand", got_v, exp_v);

      if (bus_data_ok && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (hs) m_q.push_back(src);
      if (m_lock < 0 && breq && !bus_addr_ok) m_lock = src ? 1 : 0;
      else if (m_lock >= 0 && (!req || bus_addr_ok)) m_lock = -1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
